// File: rtl/lsu_store_writer.sv
// Purpose: LSU store path; formats one store into byte lanes and strobes and
//   issues it as a single AXI4-Lite write (AW, W, B), reporting done/err.
// Latency: done_valid 3 cycles after acceptance with no stalls, 1 cycle for a
//   faulting request. Backpressure: req_ready only in IDLE, so one store is in
//   flight at a time. AW/W valids hold until their own handshakes complete;
//   each stall on AW/W or B adds exactly its length.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           store request handshake
//   req_addr/req_wdata/req_func3  byte address, rs2 data, 000 SB / 001 SH / 010 SW
//   done_valid/done_err           one-cycle completion pulse and its error flag
//   aw*, w*, b*                   AXI4-Lite write channels (master side)
module lsu_store_writer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_func3,
  output logic              done_valid,
  output logic              done_err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_n;

  logic        aw_done, w_done;
  logic        aw_hs, w_hs, send_fin, accept;
  logic        fault;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_strb;
  logic [1:0]  a;

  // Only bresp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  logic unused_bresp;
  assign unused_bresp = bresp[0];

  assign a = req_addr[1:0];

  // Handshakes are derived from state and the done flags only, so the valids
  // never depend combinationally on the readies.
  assign aw_hs    = (state == SEND) && !aw_done && awready;
  assign w_hs     = (state == SEND) && !w_done  && wready;
  assign send_fin = (aw_done || aw_hs) && (w_done || w_hs);
  assign accept   = (state == IDLE) && req_valid;

  // Lane replication, strobe generation and alignment check.
  always_comb begin
    fmt_data = req_wdata;
    fmt_strb = 4'b0000;
    fault    = 1'b1;
    case (req_func3)
      3'b000: begin
        fmt_data = {4{req_wdata[7:0]}};
        fmt_strb = 4'b0001 << a;
        fault    = 1'b0;
      end
      3'b001: begin
        fmt_data = {2{req_wdata[15:0]}};
        fmt_strb = a[1] ? 4'b1100 : 4'b0011;
        fault    = a[0];
      end
      3'b010: begin
        fmt_data = req_wdata;
        fmt_strb = 4'b1111;
        fault    = (a != 2'b00);
      end
      default: begin
        fmt_data = req_wdata;
        fmt_strb = 4'b0000;
        fault    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    done_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = fault ? DONE : SEND;
      end
      SEND: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if (send_fin) state_n = WAIT_B;
      end
      WAIT_B: begin
        bready = 1'b1;
        if (bvalid) state_n = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request payload, channel progress flags and error status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr   <= '0;
      wdata    <= '0;
      wstrb    <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      done_err <= 1'b0;
    end else begin
      if (accept) begin
        awaddr   <= {req_addr[ADDR_W-1:2], 2'b00};
        wdata    <= fmt_data;
        wstrb    <= fmt_strb;
        done_err <= fault;
      end
      if (state == SEND) begin
        if (send_fin) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
      end
      if ((state == WAIT_B) && bvalid) done_err <= bresp[1];
      // Error is only meaningful alongside done_valid; drop it afterwards.
      if (state == DONE) done_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_store_writer.sv
module tb_lsu_store_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        done_valid, done_err;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_store_writer #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .done_valid(done_valid), .done_err(done_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs set and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 of a request: present it, confirm it is accepted, then withdraw.
  task automatic accept(input logic [31:0] ad, input logic [31:0] d, input logic [2:0] f3);
    req_valid = 1'b1;
    req_addr  = ad;
    req_wdata = d;
    req_func3 = f3;
    chk("accept_req_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Best-case non-faulting store with all slaves ready; checks lanes and timing.
  task automatic store_ok(input string tag, input logic [31:0] ad, input logic [31:0] d,
                          input logic [2:0] f3, input logic [31:0] e_addr,
                          input logic [31:0] e_data, input logic [3:0] e_strb);
    accept(ad, d, f3);
    chk({tag, "_c1_awvalid"}, {31'd0, awvalid}, 32'd1);
    chk({tag, "_c1_wvalid"},  {31'd0, wvalid},  32'd1);
    chk({tag, "_c1_req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_awaddr"}, awaddr, e_addr);
    chk({tag, "_wdata"},  wdata,  e_data);
    chk({tag, "_wstrb"},  {28'd0, wstrb}, {28'd0, e_strb});
    step();
    chk({tag, "_c2_bready"}, {31'd0, bready}, 32'd1);
    chk({tag, "_c2_awvalid"}, {31'd0, awvalid}, 32'd0);
    chk({tag, "_c2_done"}, {31'd0, done_valid}, 32'd0);
    step();
    chk({tag, "_c3_done"}, {31'd0, done_valid}, 32'd1);
    chk({tag, "_c3_err"},  {31'd0, done_err},   32'd0);
    step();
    chk({tag, "_c4_done"}, {31'd0, done_valid}, 32'd0);
    chk({tag, "_c4_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Faulting request: no bus activity, done+err one cycle after acceptance.
  task automatic store_fault(input string tag, input logic [31:0] ad, input logic [2:0] f3);
    accept(ad, 32'hCAFE_F00D, f3);
    chk({tag, "_awvalid"}, {31'd0, awvalid}, 32'd0);
    chk({tag, "_wvalid"},  {31'd0, wvalid},  32'd0);
    chk({tag, "_done"},    {31'd0, done_valid}, 32'd1);
    chk({tag, "_err"},     {31'd0, done_err},   32'd1);
    step();
    chk({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_idle_done"},  {31'd0, done_valid}, 32'd0);
    chk({tag, "_idle_awvalid"}, {31'd0, awvalid}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awvalid"}, {31'd0, awvalid}, 32'd0);
    chk({tag, "_wvalid"},  {31'd0, wvalid},  32'd0);
    chk({tag, "_bready"},  {31'd0, bready},  32'd0);
    chk({tag, "_done"},    {31'd0, done_valid}, 32'd0);
    chk({tag, "_err"},     {31'd0, done_err},   32'd0);
    chk({tag, "_awaddr"},  awaddr, 32'd0);
    chk({tag, "_wdata"},   wdata,  32'd0);
    chk({tag, "_wstrb"},   {28'd0, wstrb}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_func3 = '0;
    awready   = 1'b1;
    wready    = 1'b1;
    bvalid    = 1'b1;
    bresp     = 2'b00;

    // Reset state
    step();
    step();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    step();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Best-case stores, lane formatting
    store_ok("sw", 32'h8000_0004, 32'hDEAD_BEEF, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111);
    store_ok("sb3", 32'h8000_0003, 32'h1234_56A5, 3'b000, 32'h8000_0000, 32'hA5A5_A5A5, 4'b1000);
    store_ok("sb1", 32'h1000_0011, 32'h0000_003C, 3'b000, 32'h1000_0010, 32'h3C3C_3C3C, 4'b0010);
    store_ok("sh2", 32'h8000_0002, 32'h5555_BEEF, 3'b001, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100);
    store_ok("sh0", 32'h0000_0100, 32'hFFFF_1234, 3'b001, 32'h0000_0100, 32'h1234_1234, 4'b0011);

    // Faults
    store_fault("f_sh1", 32'h8000_0001, 3'b001);
    store_fault("f_f011", 32'h8000_0000, 3'b011);
    store_fault("f_sw2", 32'h8000_0002, 3'b010);

    // AW stalled 3 cycles, W ready immediately
    awready = 1'b0;
    accept(32'h2000_0008, 32'h0BAD_F00D, 3'b010);          // now cycle 1
    chk("aws_c1_awvalid", {31'd0, awvalid}, 32'd1);
    chk("aws_c1_wvalid",  {31'd0, wvalid},  32'd1);
    step();                                                 // cycle 2
    chk("aws_c2_wvalid",  {31'd0, wvalid},  32'd0);
    chk("aws_c2_awvalid", {31'd0, awvalid}, 32'd1);
    chk("aws_c2_awaddr",  awaddr, 32'h2000_0008);
    req_valid = 1'b1;                                       // must not be taken
    req_func3 = 3'b111;
    chk("aws_c2_req_ready", {31'd0, req_ready}, 32'd0);
    step();                                                 // cycle 3
    req_valid = 1'b0;
    chk("aws_c3_awvalid", {31'd0, awvalid}, 32'd1);
    chk("aws_c3_wdata",   wdata, 32'h0BAD_F00D);
    step();                                                 // cycle 4
    awready = 1'b1;
    chk("aws_c4_awvalid", {31'd0, awvalid}, 32'd1);
    chk("aws_c4_bready",  {31'd0, bready},  32'd0);
    step();                                                 // cycle 5
    chk("aws_c5_bready",  {31'd0, bready},  32'd1);
    chk("aws_c5_done",    {31'd0, done_valid}, 32'd0);
    step();                                                 // cycle 6
    chk("aws_c6_done",    {31'd0, done_valid}, 32'd1);
    chk("aws_c6_err",     {31'd0, done_err},   32'd0);
    step();
    chk("aws_c7_done",    {31'd0, done_valid}, 32'd0);

    // B delayed 5 cycles with SLVERR
    bvalid = 1'b0;
    bresp  = 2'b10;
    accept(32'h3000_0000, 32'h1111_2222, 3'b010);          // cycle 1
    step();                                                 // cycle 2
    for (int i = 0; i < 5; i++) begin
      chk("bdly_bready", {31'd0, bready}, 32'd1);
      chk("bdly_done",   {31'd0, done_valid}, 32'd0);
      step();
    end
    bvalid = 1'b1;                                          // cycle 7
    chk("bdly_c7_bready", {31'd0, bready}, 32'd1);
    step();                                                 // cycle 8
    chk("bdly_done_valid", {31'd0, done_valid}, 32'd1);
    chk("bdly_done_err",   {31'd0, done_err},   32'd1);
    bresp = 2'b00;
    step();
    chk("bdly_after_done", {31'd0, done_valid}, 32'd0);

    // Reset pulse during WAIT_B
    bvalid = 1'b0;
    accept(32'h4000_0004, 32'h7777_8888, 3'b010);          // cycle 1
    step();                                                 // cycle 2, WAIT_B
    chk("rstb_bready", {31'd0, bready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rstb");
    step();
    rst_n = 1'b1;
    chk("rstb_release_ready", {31'd0, req_ready}, 32'd1);
    bvalid = 1'b1;
    step();
    store_ok("post_rst", 32'h4000_0010, 32'h0102_0304, 3'b010, 32'h4000_0010, 32'h0102_0304, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_store_writer.md
# lsu_store_writer

Store-side counterpart of the load data path in the NPC LSU. Accepts one store request (address, register data, func3), checks alignment, replicates the data into its byte lanes and generates write strobes. It then performs one AXI4-Lite write transaction (AW, W, B channels) and reports completion and error status back to the pipeline. Only one store is outstanding at a time.

## Interface
- ADDR_W, 32, address width of req_addr and awaddr
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_addr  in  ADDR_W  byte address of store
- req_wdata  in  32  rs2 value, data in low bits
- req_func3  in  3  000 SB, 001 SH, 010 SW; all other codes illegal
- done_valid  out  1  one-cycle completion pulse
- done_err  out  1  qualifies done_valid: illegal func3, misaligned, or bus error
- awvalid/awready  out/in  1  AXI write-address handshake
- awaddr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
- wvalid/wready  out/in  1  AXI write-data handshake
- wdata  out  32  lane-replicated store data
- wstrb  out  4  byte enables
- bvalid  in  1, bready  out  1, bresp  in  2  AXI write response

## Operation
- Lane formatting, registered at acceptance, with a = req_addr[1:0]:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<a.
  - SH: wdata={2{d[15:0]}}, wstrb=a[1]?4'b1100:4'b0011.
  - SW: wdata=d, wstrb=4'b1111.
- Fault on acceptance: illegal func3, SH with a[0]=1, or SW with a!=0. A fault issues no bus activity and goes straight to DONE with done_err=1.
- FSM states: IDLE, SEND, WAIT_B, DONE.
  - IDLE: req_ready=1. On req_valid, latch awaddr/wdata/wstrb. Go to SEND, or to DONE on a fault.
  - SEND: awvalid=!aw_done, wvalid=!w_done. aw_done sets on awvalid&&awready; w_done sets on wvalid&&wready. Either order and same-cycle completion are legal. When both are done (including the completing cycle), clear both flags and go to WAIT_B.
  - WAIT_B: bready=1. On bvalid, capture done_err=bresp[1] (SLVERR/DECERR) and go to DONE.
  - DONE: done_valid=1 for exactly one cycle with done_err held, then go to IDLE.
- AXI rules:
  - A valid stays high until its handshake completes.
  - awaddr/wdata/wstrb are stable from SEND entry until WAIT_B.
  - No valid depends combinationally on a ready.
- bvalid outside WAIT_B is ignored. awready/wready outside SEND are ignored.

## Timing
- Reset, asynchronous, effective immediately, including mid-transaction:
  - State returns to IDLE; in-flight transaction is abandoned.
  - awvalid=0, wvalid=0, bready=0, done_valid=0, done_err=0, awaddr=0, wdata=0, wstrb=0, aw_done=w_done=0.
  - req_ready=1 in the first cycle after rst_n deasserts.
- Best case, ready/bvalid always high:
  - Accept in cycle 0, AW+W handshake in cycle 1, B handshake in cycle 2, done_valid in cycle 3. Latency 3 cycles.
  - Next request can be accepted in cycle 4.
- Fault path: accept in cycle 0, done_valid with done_err=1 in cycle 1.
- Every stall adds exactly its length: SEND until the later of AW and W completes, WAIT_B until bvalid.
- req_ready=0 from the cycle after acceptance through DONE. Requests in that window are not taken.

## Test plan
- SW addr=0x8000_0004 data=0xDEADBEEF, slaves always ready, bresp=0 -> awaddr=0x8000_0004, wdata=0xDEADBEEF, wstrb=1111; done_valid in cycle 3, done_err=0.
- SB addr=...03 data=0x1234_56A5 -> wdata=0xA5A5A5A5, wstrb=1000. SH addr=...02 data=0xXXXX_BEEF -> wdata=0xBEEFBEEF, wstrb=1100.
- SH addr=...01, then func3=011 -> no awvalid/wvalid ever; done_valid+done_err=1 one cycle after acceptance.
- awready held low 3 cycles while wready is high -> W completes in cycle 1, wvalid drops; awvalid stays high with stable awaddr until handshake in cycle 4; done_valid in cycle 6.
- bvalid delayed 5 cycles with bresp=2'b10 -> bready held throughout; done_err=1 on done_valid.
- rst_n pulsed low during WAIT_B -> all outputs at reset values immediately; req_ready=1 after release; a new SW completes normally.
